// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for mem_port_arbiter and its picker.
package mem_arb_pkg;

  localparam int unsigned NCORES_DEF = 4;
  localparam int unsigned LD_LAT_DEF = 2;
  localparam int unsigned AW_DEF     = 16;
  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned CIDW       = $clog2(NCORES_DEF);

  // One stage of the in-flight load tracker.
  typedef struct packed {
    logic            valid;
    logic [CIDW-1:0] core;
  } ld_tag_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_LD,
    OP_ST
  } op_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/grant/response bus plus the memory-side strobes.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCORES = NCORES_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF
);

  logic [NCORES-1:0]    req_ld;
  logic [NCORES-1:0]    req_st;
  logic [NCORES*AW-1:0] ld_addr;
  logic [NCORES*AW-1:0] st_addr;
  logic [NCORES*DW-1:0] st_data;
  logic [NCORES-1:0]    gnt_ld;
  logic [NCORES-1:0]    gnt_st;
  logic                 mem_ld_en;
  logic [AW-1:0]        mem_ld_addr;
  logic                 mem_st_en;
  logic [AW-1:0]        mem_st_addr;
  logic [DW-1:0]        mem_st_data;
  logic [DW-1:0]        mem_ld_data;
  logic [NCORES-1:0]    rsp_valid;
  logic [DW-1:0]        rsp_data;

  modport slave (
    input  req_ld, req_st, ld_addr, st_addr, st_data, mem_ld_data,
    output gnt_ld, gnt_st, mem_ld_en, mem_ld_addr, mem_st_en,
           mem_st_addr, mem_st_data, rsp_valid, rsp_data
  );

  modport master (
    output req_ld, req_st, ld_addr, st_addr, st_data, mem_ld_data,
    input  gnt_ld, gnt_st, mem_ld_en, mem_ld_addr, mem_st_en,
           mem_st_addr, mem_st_data, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// N-way round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  // Scan N slots starting at ptr; the first hit wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_c && req[(32'(ptr) + k) % N]) begin
        any_c                     = 1'b1;
        gnt_c[(32'(ptr) + k) % N] = 1'b1;
        idx_c                     = IW'((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory load port and one store port among
// NCORES cores, with in-flight load tagging to route read data back.
// Optional macro MEM_ARB_STORE_FIRST_EN: any pending store beats all loads.
// NCORES must fit the package core-id width (CIDW).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCORES = NCORES_DEF,
  parameter int unsigned LD_LAT = LD_LAT_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  logic [CIDW-1:0] rr_ptr_q, rr_ptr_d;
  logic            mem_ld_en_q, mem_ld_en_d;
  logic [AW-1:0]   mem_ld_addr_q, mem_ld_addr_d;
  logic [CIDW-1:0] ld_core_q, ld_core_d;
  logic            mem_st_en_q, mem_st_en_d;
  logic [AW-1:0]   mem_st_addr_q, mem_st_addr_d;
  logic [DW-1:0]   mem_st_data_q, mem_st_data_d;
  ld_tag_t         tag_q [LD_LAT];
  ld_tag_t         tag_d [LD_LAT];

  op_t               op;
  logic [CIDW-1:0]   win_idx;
  logic [NCORES-1:0] win_gnt;

`ifdef MEM_ARB_STORE_FIRST_EN
  logic [NCORES-1:0] st_gnt, ld_gnt;
  logic [CIDW-1:0]   st_idx, ld_idx;
  logic              st_any, ld_any;

  rr_pick #(.N(NCORES), .IW(CIDW)) u_pick_st (
    .req(bus.req_st), .ptr(rr_ptr_q), .gnt_c(st_gnt), .idx_c(st_idx), .any_c(st_any)
  );

  rr_pick #(.N(NCORES), .IW(CIDW)) u_pick_ld (
    .req(bus.req_ld), .ptr(rr_ptr_q), .gnt_c(ld_gnt), .idx_c(ld_idx), .any_c(ld_any)
  );

  // Store class first; loads only when no store is pending anywhere.
  always_comb begin
    op      = OP_NONE;
    win_idx = '0;
    win_gnt = '0;
    if (st_any) begin
      op      = OP_ST;
      win_idx = st_idx;
      win_gnt = st_gnt;
    end else if (ld_any) begin
      op      = OP_LD;
      win_idx = ld_idx;
      win_gnt = ld_gnt;
    end
  end
`else
  logic [NCORES-1:0] any_req, any_gnt;
  logic [CIDW-1:0]   any_idx;
  logic              any_any;

  assign any_req = bus.req_ld | bus.req_st;

  rr_pick #(.N(NCORES), .IW(CIDW)) u_pick (
    .req(any_req), .ptr(rr_ptr_q), .gnt_c(any_gnt), .idx_c(any_idx), .any_c(any_any)
  );

  // One ring over cores; a core's store outranks its own load.
  always_comb begin
    op      = OP_NONE;
    win_idx = '0;
    win_gnt = '0;
    if (any_any) begin
      op      = (|(any_gnt & bus.req_st)) ? OP_ST : OP_LD;
      win_idx = any_idx;
      win_gnt = any_gnt;
    end
  end
`endif

  // Combinational grants for the requesting cores.
  always_comb begin
    bus.gnt_ld = (op == OP_LD) ? win_gnt : '0;
    bus.gnt_st = (op == OP_ST) ? win_gnt : '0;
  end

  // Next state: memory operands, pointer advance and load-tag shift.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    mem_ld_en_d   = 1'b0;
    mem_ld_addr_d = mem_ld_addr_q;
    ld_core_d     = ld_core_q;
    mem_st_en_d   = 1'b0;
    mem_st_addr_d = mem_st_addr_q;
    mem_st_data_d = mem_st_data_q;
    case (op)
      OP_LD: begin
        mem_ld_en_d   = 1'b1;
        mem_ld_addr_d = bus.ld_addr[32'(win_idx)*AW +: AW];
        ld_core_d     = win_idx;
      end
      OP_ST: begin
        mem_st_en_d   = 1'b1;
        mem_st_addr_d = bus.st_addr[32'(win_idx)*AW +: AW];
        mem_st_data_d = bus.st_data[32'(win_idx)*DW +: DW];
      end
      default: ;
    endcase
    if (op != OP_NONE) begin
      rr_ptr_d = (win_idx == CIDW'(NCORES-1)) ? '0 : win_idx + CIDW'(1);
    end
    // Tag enters alongside the registered strobe, emerges with read data.
    tag_d[0] = '{valid: mem_ld_en_q, core: ld_core_q};
    for (int unsigned s = 1; s < LD_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // State registers; reset clears strobes and the in-flight tracker at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      mem_ld_en_q   <= 1'b0;
      mem_ld_addr_q <= '0;
      ld_core_q     <= '0;
      mem_st_en_q   <= 1'b0;
      mem_st_addr_q <= '0;
      mem_st_data_q <= '0;
      for (int unsigned s = 0; s < LD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mem_ld_en_q   <= mem_ld_en_d;
      mem_ld_addr_q <= mem_ld_addr_d;
      ld_core_q     <= ld_core_d;
      mem_st_en_q   <= mem_st_en_d;
      mem_st_addr_q <= mem_st_addr_d;
      mem_st_data_q <= mem_st_data_d;
      tag_q         <= tag_d;
    end
  end

  assign bus.mem_ld_en   = mem_ld_en_q;
  assign bus.mem_ld_addr = mem_ld_addr_q;
  assign bus.mem_st_en   = mem_st_en_q;
  assign bus.mem_st_addr = mem_st_addr_q;
  assign bus.mem_st_data = mem_st_data_q;

  // Route the returning word to the core named by the emerging tag.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (tag_q[LD_LAT-1].valid) begin
      bus.rsp_valid[tag_q[LD_LAT-1].core] = 1'b1;
      bus.rsp_data                        = bus.mem_ld_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (works with or without
// MEM_ARB_STORE_FIRST_EN).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NC  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.NCORES(NC), .LD_LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Environment memory: writes at issue, read data LAT cycles after strobe.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [LAT];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_st_en) env_mem[bus.mem_st_addr] = bus.mem_st_data;
    for (int s = LAT - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
    if (bus.mem_ld_en)
      rd_pipe[0] <= env_mem.exists(bus.mem_ld_addr) ? env_mem[bus.mem_ld_addr]
                                                    : init_val(bus.mem_ld_addr);
    else
      rd_pipe[0] <= 16'hDEAD;
  end
  assign bus.mem_ld_data = rd_pipe[LAT-1];

  // Reference model state
  typedef struct {
    int unsigned   due;
    int unsigned   core;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] sh_mem [logic [AW-1:0]];
  int unsigned   m_ptr;
  logic          m_ld_en, m_st_en;
  logic [AW-1:0] m_ld_addr, m_st_addr;
  logic [DW-1:0] m_st_data;
  int unsigned   cyc;
  int            n_chk, n_pass;

  typedef struct {
    logic [NC-1:0] ld, st, gl, gs;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return sh_mem.exists(a) ? sh_mem[a] : init_val(a);
  endfunction

  // Winner from the arbitration rules: scan cores from the pointer, wrapping.
  task automatic model_pick(input logic [NC-1:0] ld, input logic [NC-1:0] st,
                            output int win, output bit is_st);
    win   = -1;
    is_st = 1'b0;
`ifdef MEM_ARB_STORE_FIRST_EN
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (int'(m_ptr) + k) % NC;
      if (win < 0 && st != '0 && st[c]) begin win = c; is_st = 1'b1; end
      if (win < 0 && st == '0 && ld[c]) win = c;
    end
`else
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (int'(m_ptr) + k) % NC;
      if (win < 0 && (ld[c] || st[c])) begin win = c; is_st = st[c]; end
    end
`endif
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_ld_en = 1'b0;
    m_st_en = 1'b0;
    rq.delete();
  endtask

  task automatic check_regs();
    logic [NC-1:0] ev;
    logic [DW-1:0] ed;
    chk("mem_ld_en", 32'(bus.mem_ld_en), 32'(m_ld_en));
    if (m_ld_en) chk("mem_ld_addr", 32'(bus.mem_ld_addr), 32'(m_ld_addr));
    chk("mem_st_en", 32'(bus.mem_st_en), 32'(m_st_en));
    if (m_st_en) begin
      chk("mem_st_addr", 32'(bus.mem_st_addr), 32'(m_st_addr));
      chk("mem_st_data", 32'(bus.mem_st_data), 32'(m_st_data));
    end
    ev = '0;
    ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev[rq[0].core] = 1'b1;
      ed             = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    if (ev != '0) chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
  endtask

  // One cycle: drive at negedge, check grants, advance model, check registers.
  task automatic step(input logic [NC-1:0] ld, input logic [NC-1:0] st,
                      input bit use_exp = 1'b0,
                      input logic [NC-1:0] e_gl = '0, input logic [NC-1:0] e_gs = '0);
    int            win;
    bit            is_st;
    logic [NC-1:0] gl, gs;
    bus.req_ld = ld;
    bus.req_st = st;
    #1;
    model_pick(ld, st, win, is_st);
    gl = '0;
    gs = '0;
    if (win >= 0) begin
      if (is_st) gs[win] = 1'b1;
      else       gl[win] = 1'b1;
    end
    chk("gnt_ld", 32'(bus.gnt_ld), 32'(gl));
    chk("gnt_st", 32'(bus.gnt_st), 32'(gs));
    if (use_exp) begin
      chk("dir_gnt_ld", 32'(bus.gnt_ld), 32'(e_gl));
      chk("dir_gnt_st", 32'(bus.gnt_st), 32'(e_gs));
    end
    m_ld_en = 1'b0;
    m_st_en = 1'b0;
    if (win >= 0) begin
      m_ptr = (win + 1) % NC;
      if (is_st) begin
        m_st_en   = 1'b1;
        m_st_addr = bus.st_addr[win*AW +: AW];
        m_st_data = bus.st_data[win*DW +: DW];
        sh_mem[m_st_addr] = m_st_data;
      end else begin
        m_ld_en   = 1'b1;
        m_ld_addr = bus.ld_addr[win*AW +: AW];
        rq.push_back('{due: cyc + 1 + LAT, core: win, data: sh_rd(m_ld_addr)});
      end
    end
    @(negedge clk);
    cyc++;
    check_regs();
  endtask

  task automatic set_core(input int c, input logic [AW-1:0] la,
                          input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    bus.ld_addr[c*AW +: AW] = la;
    bus.st_addr[c*AW +: AW] = sa;
    bus.st_data[c*DW +: DW] = sd;
  endtask

  task automatic rand_addrs();
    for (int c = 0; c < NC; c++)
      set_core(c, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), DW'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    bus.req_ld = '0;
    bus.req_st = '0;
    repeat (n) @(negedge clk);
    cyc += n;
    chk("rst_gnt", 32'({bus.gnt_ld, bus.gnt_st}), 32'(0));
    chk("rst_en", 32'({bus.mem_ld_en, bus.mem_st_en}), 32'(0));
    chk("rst_addr", {bus.mem_ld_addr, bus.mem_st_addr}, 32'(0));
    chk("rst_stdata", 32'(bus.mem_st_data), 32'(0));
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'(0));
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    bus.req_ld = '0;
    bus.req_st = '0;
    bus.ld_addr = '0;
    bus.st_addr = '0;
    bus.st_data = '0;
    model_reset();

    // Directed arbitration vectors from a reset pointer of 0.
    tbl[0]  = '{ld: 4'b0000, st: 4'b0000, gl: 4'b0000, gs: 4'b0000};
    tbl[1]  = '{ld: 4'b0100, st: 4'b0000, gl: 4'b0100, gs: 4'b0000};
    tbl[2]  = '{ld: 4'b1111, st: 4'b0000, gl: 4'b1000, gs: 4'b0000};
    tbl[3]  = '{ld: 4'b0001, st: 4'b0001, gl: 4'b0000, gs: 4'b0001};
    tbl[4]  = '{ld: 4'b0001, st: 4'b0000, gl: 4'b0001, gs: 4'b0000};
    tbl[5]  = '{ld: 4'b1111, st: 4'b1111, gl: 4'b0000, gs: 4'b0010};
    tbl[6]  = '{ld: 4'b0011, st: 4'b0000, gl: 4'b0001, gs: 4'b0000};
    tbl[7]  = '{ld: 4'b0000, st: 4'b1000, gl: 4'b0000, gs: 4'b1000};
    tbl[8]  = '{ld: 4'b1000, st: 4'b0001, gl: 4'b0000, gs: 4'b0001};
    tbl[9]  = '{ld: 4'b0000, st: 4'b0000, gl: 4'b0000, gs: 4'b0000};
    tbl[10] = '{ld: 4'b0001, st: 4'b0100, gl: 4'b0000, gs: 4'b0100};
    tbl[11] = '{ld: 4'b1000, st: 4'b0000, gl: 4'b1000, gs: 4'b0000};
`ifdef MEM_ARB_STORE_FIRST_EN
    tbl[12] = '{ld: 4'b0001, st: 4'b1000, gl: 4'b0000, gs: 4'b1000};
`else
    tbl[12] = '{ld: 4'b0001, st: 4'b1000, gl: 4'b0001, gs: 4'b0000};
`endif

    // Reset then idle
    @(negedge clk);
    do_reset(3);
    repeat (10) step('0, '0);

    // Table-driven arbitration
    for (int i = 0; i < 13; i++) begin
      rand_addrs();
      step(tbl[i].ld, tbl[i].st, 1'b1, tbl[i].gl, tbl[i].gs);
    end
    repeat (LAT + 1) step('0, '0);

    // Single load from core 2
    do_reset(1);
    set_core(2, 16'h0040, 16'h0000, 16'h0000);
    step(4'b0100, '0, 1'b1, 4'b0100, 4'b0000);
    chk("single_ld_en", 32'(bus.mem_ld_en), 32'(1));
    chk("single_ld_addr", 32'(bus.mem_ld_addr), 32'h0040);
    step('0, '0);
    chk("single_early", 32'(bus.rsp_valid), 32'(0));
    step('0, '0);
    chk("single_rsp_v", 32'(bus.rsp_valid), 32'(4'b0100));
    chk("single_rsp_d", 32'(bus.rsp_data), 32'hBEEF);

    // Fairness: all cores hold loads from reset
    do_reset(1);
    rand_addrs();
    begin
      logic [NC-1:0] order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      for (int i = 0; i < 5; i++) step(4'b1111, '0, 1'b1, order[i], '0);
    end
    repeat (LAT + 1) step('0, '0);

    // Store then load, same core and address
    set_core(1, 16'h0010, 16'h0010, 16'h1234);
    step('0, 4'b0010, 1'b1, '0, 4'b0010);
    chk("sl_st_first", 32'({bus.mem_st_en, bus.mem_ld_en}), 32'(2'b10));
    step(4'b0010, '0, 1'b1, 4'b0010, '0);
    step('0, '0);
    step('0, '0);
    chk("sl_rsp_v", 32'(bus.rsp_valid), 32'(4'b0010));
    chk("sl_rsp_d", 32'(bus.rsp_data), 32'h1234);

    // Same-core conflict, then cross-core store against core-0 load
    do_reset(1);
    rand_addrs();
    step(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000);
    do_reset(1);
`ifdef MEM_ARB_STORE_FIRST_EN
    step(4'b0001, 4'b1000, 1'b1, 4'b0000, 4'b1000);
`else
    step(4'b0001, 4'b1000, 1'b1, 4'b0001, 4'b0000);
`endif
    repeat (LAT + 1) step('0, '0);

    // Reset while a load is in flight
    do_reset(1);
    step(4'b0100, '0, 1'b1, 4'b0100, '0);
    step('0, '0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'({bus.mem_ld_en, bus.mem_st_en}), 32'(0));
    chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'(0));
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step('0, '0);
      chk("mid_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
    step(4'b1111, '0, 1'b1, 4'b0001, '0);

    // Randomized traffic against the model
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      rand_addrs();
      step(NC'($urandom), NC'($urandom) & NC'($urandom));
    end
    repeat (LAT + 2) step('0, '0);
    chk("drain", rq.size(), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single tape-memory load port and store port among NCORES select units.
- Replaces the daisy-chained ld_en/st_en priority with round-robin arbitration.
- Tracks in-flight loads across the fixed memory read latency and routes each returned word to the core that issued it.
- Sits between the per-core select units and the data memory.

Parameters:
- NCORES, 4, number of requesting cores (>=2).
- LD_LAT, 2, cycles from mem_ld_en to valid mem_ld_data (>=1).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_ld  input  NCORES  per-core load request; level, held until granted.
- req_st  input  NCORES  per-core store request; level, held until granted.
- ld_addr  input  NCORES*AW  per-core load address; core i occupies slice [i*AW +: AW].
- st_addr  input  NCORES*AW  per-core store address; same slicing.
- st_data  input  NCORES*DW  per-core store data; same slicing.
- gnt_ld  output  NCORES  one-hot load grant; combinational, same cycle as the request.
- gnt_st  output  NCORES  one-hot store grant; combinational.
- mem_ld_en  output  1  registered memory read strobe.
- mem_ld_addr  output  AW  registered read address.
- mem_st_en  output  1  registered memory write strobe.
- mem_st_addr  output  AW  registered write address.
- mem_st_data  output  DW  registered write data.
- mem_ld_data  input  DW  read data, valid LD_LAT cycles after mem_ld_en.
- rsp_valid  output  NCORES  one-hot: load data for core i is valid this cycle.
- rsp_data  output  DW  returned load data; equals mem_ld_data when any rsp_valid bit is set.

Behaviour:
- Reset values: all grants 0, mem_* enables 0, addresses and data 0, rsp_valid 0, rr_ptr 0, in-flight pipeline cleared.
- Each cycle at most one operation is granted, either one load or one store.
- Candidate per core: a store if req_st[i], otherwise a load if req_ld[i]. A store beats a load from the same core.
- Winner: the first requesting core scanning from rr_ptr upward, wrapping modulo NCORES.
- On a grant, rr_ptr <= (winner+1) mod NCORES. With no request, rr_ptr holds.
- Grant cycle N drives the mem_* strobe and registered operands in cycle N+1. The requester deasserts its request in N+1.
- A core holding its request after a grant is treated as a new request.
- Load tracking: a shift pipeline of depth LD_LAT carrying {valid, core_id}, loaded when mem_ld_en is registered.
  - The stage emerging in the cycle mem_ld_data is valid drives rsp_valid[core_id] = 1.
  - rsp_data = mem_ld_data in that cycle.
- Total latency from load grant to rsp_valid is 1+LD_LAT cycles.
- Up to LD_LAT loads may be in flight back-to-back with no bubbles. Responses return in issue order.
- Ordering: stores and loads reach memory in grant order. A load granted after a store to the same address returns the stored value, since memory writes at issue.
- A core issuing a load and then a store in consecutive grants is legal. The store does not affect the earlier load's data.
- Simultaneous req_ld and req_st on all cores: exactly one store is granted, and rr_ptr advances past that core.
- Single requester holding its request continuously: granted every cycle.
- Reset asserted mid-operation: pipeline is cleared immediately (asynchronously).
  - No rsp_valid for loads issued before reset.
  - mem_* enables drop to 0 asynchronously.

Optional Feature:
- Macro: MEM_ARB_STORE_FIRST_EN.
- Defined: any pending store in any core beats all loads. Round-robin runs among store requesters first, then among load requesters when no store is pending. rr_ptr is shared by both classes.
- Undefined: single round-robin over cores, with a store beating a load only within the same core, as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - localparams for the core-id width ($clog2(NCORES)) and LD_LAT default;
  - a packed struct ld_tag_t {logic valid; logic [CIDW-1:0] core;};
  - an enum op_t {OP_NONE, OP_LD, OP_ST}.
- Sub-module rr_pick: a parameterised N-way round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once, or twice when MEM_ARB_STORE_FIRST_EN is defined.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high, no requests -> all outputs 0, rsp_valid never asserted over 10 cycles.
- Single load: core 2 req_ld, ld_addr=16'h0040, memory holds 16'hBEEF -> gnt_ld=4'b0100 at cycle N, mem_ld_en/addr 0040 at N+1, rsp_valid=4'b0100 with rsp_data=BEEF at N+3.
- Fairness: all four cores hold req_ld from reset -> grants in order 0,1,2,3,0. Four consecutive mem_ld_en cycles, responses tagged 0,1,2,3 in order.
- Store then load same address: core 1 stores 16'h1234 to 0x10, core 1 then loads 0x10 -> mem_st_en precedes mem_ld_en, rsp_data=1234.
- Same-core conflict: core 0 asserts req_ld and req_st together -> gnt_st=0001 first, gnt_ld=0001 on a later grant. With MEM_ARB_STORE_FIRST_EN, a core-3 store beats core-0 loads even when rr_ptr=0.
- Reset mid-flight: load granted, rst_n pulsed low one cycle after mem_ld_en -> no rsp_valid for that load; rr_ptr back to 0.
